branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
Execute-stage branch/jump resolution stage that consumes the signed and unsigned comparator flags (equal/alarger/blarger) and decides branch outcome against the fetch-stage prediction. Registers the decision for one cycle and drives fetch redirect and pipeline flush. Squashes wrong-path instructions in its own input during the flush window. Keeps saturating branch and mispredict statistics counters.

Parameters:
XLEN, 32, datapath/PC width
KILL_CYCLES, 1, input beats ignored after a redirect (1..3)
CNT_W, 16, width of statistics counters (saturating)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
stall_i  in  1  hold stage: no sampling, outputs and state frozen
valid_i  in  1  input instruction valid
is_branch_i  in  1  conditional branch
is_jal_i  in  1  JAL
is_jalr_i  in  1  JALR
funct3_i  in  3  branch condition code
pc_i  in  XLEN  instruction PC
imm_i  in  XLEN  sign-extended immediate
rs1_i  in  XLEN  JALR base operand
eq_s_i, alarger_s_i, blarger_s_i  in  1 each  signed compare flags (rs1 vs rs2)
eq_u_i, alarger_u_i, blarger_u_i  in  1 each  unsigned compare flags
pred_taken_i  in  1  fetch prediction taken
pred_pc_i  in  XLEN  fetch predicted target
valid_o  out  1  registered instruction resolved
taken_o  out  1  actual taken
link_o  out  XLEN  pc_i+4 (rd value for JAL/JALR)
redirect_o  out  1  one-cycle redirect pulse
redirect_pc_o  out  XLEN  correct next PC
flush_o  out  1  one-cycle flush of IF/ID, same cycle as redirect_o
illegal_o  out  1  branch with funct3 010/011
br_cnt_o  out  CNT_W  resolved control-transfer count
mis_cnt_o  out  CNT_W  mispredict count

Behaviour:
- Reset: all outputs 0, counters 0, squash counter 0; asserted asynchronously, released synchronously by flop design.
- Condition: 000 eq_s; 001 ~eq_s; 100 blarger_s; 101 ~blarger_s; 110 blarger_u; 111 ~blarger_u; 010/011 not taken and illegal. JAL/JALR always taken. Non-control valid instr: not taken, no counter update, never mispredicts unless pred_taken_i=1.
- Target: branch/JAL = pc_i+imm_i; JALR = (rs1_i+imm_i) with bit0 cleared. All sums modulo 2^XLEN (wrap, no flag).
- Mispredict = actual_taken != pred_taken_i, or (actual_taken and target != pred_pc_i).
- redirect_pc_o = target if taken, else pc_i+4.
- Latency 1: inputs sampled at edge N with valid_i=1, stall_i=0, squash=0 appear on outputs in cycle N+1. valid_o/redirect_o/flush_o/illegal_o are single-cycle pulses unless stall_i holds them.
- Squash: on redirect, squash counter loads KILL_CYCLES; each non-stalled cycle with counter>0 ignores the input (valid_o=0) and decrements. A second redirect cannot occur while squashing.
- Stall: stall_i=1 freezes all registers including counters and squash counter; outputs hold values.
- Counters: br_cnt_o +1 per resolved branch/JAL/JALR; mis_cnt_o +1 per mispredict; both saturate at all-ones.
- Multiple type bits set: priority jalr > jal > branch.

Decomposition:
- Package branch_pkg: funct3 enum (BEQ,BNE,BLT,BGE,BLTU,BGEU), XLEN default, resolve-result struct (taken, target, mispredict, illegal).
- Sub-module branch_cond: combinational funct3 + flags -> taken, illegal.

Test Plan:
- BEQ pc=0x100 imm=0x20 eq_s=1 pred_taken=0 -> next cycle taken_o=1, redirect_o=1, flush_o=1, redirect_pc_o=0x120, mis_cnt_o=1.
- BLTU blarger_u=1 pred_taken=1 pred_pc=0x120 (pc 0x100, imm 0x20) -> taken_o=1, redirect_o=0, br_cnt_o+1, mis_cnt_o unchanged.
- JALR rs1=0x1003 imm=0x4 pred_taken=0 -> redirect_pc_o=0x1006, link_o=pc+4, redirect_o=1; following valid input ignored (valid_o=0).
- BGE mispredict then stall_i=1 for 3 cycles -> redirect_o and flush_o held 3 cycles, counters unchanged; squash consumes first non-stalled beat.
- funct3=010 branch -> illegal_o=1, taken_o=0; pred_taken=1 -> redirect_pc_o=pc+4.
- pc=0xFFFFFFFC imm=8 taken -> redirect_pc_o=0x4; rst_ni low mid-flush -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for the execute-stage branch resolver: condition codes and
// the per-instruction resolution record.
package branch_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } funct3_e;

  typedef struct packed {
    logic                taken;
    logic [XLEN_DEF-1:0] target;
    logic                mispredict;
    logic                illegal;
  } resolve_t;

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// Conditional-branch outcome from funct3 and the comparator flags (rs1 vs rs2).
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       eq_s,
  input  logic       blarger_s,
  input  logic       blarger_u,
  output logic       taken,
  output logic       illegal
);

  // blarger means rs2 > rs1, so "less than" is blarger and "greater or equal" its complement
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3_e'(funct3))
      BEQ:     taken = eq_s;
      BNE:     taken = ~eq_s;
      BLT:     taken = blarger_s;
      BGE:     taken = ~blarger_s;
      BLTU:    taken = blarger_u;
      BGEU:    taken = ~blarger_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution: compares the actual outcome with the
// fetch prediction, registers redirect/flush for one cycle and squashes wrong-path beats.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int KILL_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             valid_i,
  input  logic             is_branch_i,
  input  logic             is_jal_i,
  input  logic             is_jalr_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic             eq_s_i,
  input  logic             alarger_s_i,
  input  logic             blarger_s_i,
  input  logic             eq_u_i,
  input  logic             alarger_u_i,
  input  logic             blarger_u_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  pred_pc_i,
  output logic             valid_o,
  output logic             taken_o,
  output logic [XLEN-1:0]  link_o,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mis_cnt_o
);

  localparam int              SQ_W    = 2;
  localparam logic [SQ_W-1:0] KILL_LD = SQ_W'(KILL_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             cond_taken;
  logic             cond_illegal;
  logic             is_ctrl;
  logic             accept;
  logic [XLEN-1:0]  link;
  logic [XLEN-1:0]  jalr_sum;
  resolve_t         res;
  logic             unused_flags;

  logic             vld_p1;
  logic             taken_p1;
  logic [XLEN-1:0]  link_p1;
  logic             redir_p1;
  logic [XLEN-1:0]  rpc_p1;
  logic             ill_p1;
  logic [SQ_W-1:0]  sq_cnt_p1;
  logic [CNT_W-1:0] br_cnt_p1;
  logic [CNT_W-1:0] mis_cnt_p1;

  // Only eq_s/blarger_s/blarger_u decide the six conditions
  assign unused_flags = ^{alarger_s_i, eq_u_i, alarger_u_i};

  branch_cond u_cond (
    .funct3    (funct3_i),
    .eq_s      (eq_s_i),
    .blarger_s (blarger_s_i),
    .blarger_u (blarger_u_i),
    .taken     (cond_taken),
    .illegal   (cond_illegal)
  );

  // ---- p0: combinational resolve of the incoming beat ----
  assign is_ctrl  = is_branch_i | is_jal_i | is_jalr_i;
  assign accept   = valid_i & ~stall_i & (sq_cnt_p1 == '0);
  assign link     = pc_i + XLEN'(4);
  assign jalr_sum = rs1_i + imm_i;

  always_comb begin
    res        = '0;
    res.target = pc_i + imm_i;
    if (is_jalr_i) begin
      res.taken  = 1'b1;
      res.target = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (is_jal_i) begin
      res.taken = 1'b1;
    end else if (is_branch_i) begin
      res.taken   = cond_taken;
      res.illegal = cond_illegal;
    end
    res.mispredict = (res.taken != pred_taken_i) ||
                     (res.taken && (res.target != pred_pc_i));
  end

  // ---- p1: registered decision, squash window and statistics ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1     <= 1'b0;
      taken_p1   <= 1'b0;
      link_p1    <= '0;
      redir_p1   <= 1'b0;
      rpc_p1     <= '0;
      ill_p1     <= 1'b0;
      sq_cnt_p1  <= '0;
      br_cnt_p1  <= '0;
      mis_cnt_p1 <= '0;
    end else if (!stall_i) begin
      vld_p1   <= accept;
      redir_p1 <= accept & res.mispredict;
      ill_p1   <= accept & res.illegal;
      if (accept) begin
        taken_p1 <= res.taken;
        link_p1  <= link;
        rpc_p1   <= res.taken ? res.target : link;
      end
      if (accept && res.mispredict) begin
        sq_cnt_p1 <= KILL_LD;
      end else if (sq_cnt_p1 != '0) begin
        sq_cnt_p1 <= sq_cnt_p1 - SQ_W'(1);
      end
      if (accept && is_ctrl) begin
        br_cnt_p1 <= sat_inc(br_cnt_p1);
        if (res.mispredict) begin
          mis_cnt_p1 <= sat_inc(mis_cnt_p1);
        end
      end
    end
  end

  assign valid_o       = vld_p1;
  assign taken_o       = taken_p1;
  assign link_o        = link_p1;
  assign redirect_o    = redir_p1;
  assign redirect_pc_o = rpc_p1;
  assign flush_o       = redir_p1;
  assign illegal_o     = ill_p1;
  assign br_cnt_o      = br_cnt_p1;
  assign mis_cnt_o     = mis_cnt_p1;

endmodule
